// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable watermarks,
// sticky overflow/underflow flags and a build-time choice of FWFT or registered read.
module fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_CNT    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0]   AE_CNT    = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  if (AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_levels
    $error("fifo_param: watermarks must satisfy 0 <= AE_LEVEL < AF_LEVEL <= 2**ADDR_WIDTH");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
  logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc, rd_acc;

  // Status is decoded from the count register alone so it never sees rd/wr.
  assign full         = (count_q == DEPTH_CNT);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    count_d     = count_q;
    wr_acc      = wr && (!full || rd);
    rd_acc      = rd && !empty;

    if (wr_acc) w_ptr_d = w_ptr_q + PTR_ONE;
    if (rd_acc) r_ptr_d = r_ptr_q + PTR_ONE;

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // A fresh error in the same cycle as err_clr must survive the clear.
    overflow_d  = (overflow_q  && !err_clr) || (wr && full && !rd);
    underflow_d = (underflow_q && !err_clr) || (rd && empty);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (wr_acc && !reset) mem_q[w_ptr_q] <= w_data;
  end

  if (FWFT != 0) begin : g_fwft
    assign r_data  = mem_q[r_ptr_q];
    assign r_valid = !empty;
  end else begin : g_reg_read
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic                  r_valid_q, r_valid_d;

    always_comb begin
      r_data_d  = r_data_q;
      r_valid_d = rd_acc;
      if (rd_acc) r_data_d = mem_q[r_ptr_q];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_data_q  <= '0;
        r_valid_q <= 1'b0;
      end else begin
        r_data_q  <= r_data_d;
        r_valid_q <= r_valid_d;
      end
    end

    assign r_data  = r_data_q;
    assign r_valid = r_valid_q;
  end

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: a queue-based reference model predicts every
// output after each edge; a second instance exercises the FWFT read mode.
module tb_fifo_param;

  logic       clk = 1'b0;
  logic       reset, wr, rd, err_clr;
  logic [7:0] w_data;
  logic [7:0] r_data;
  logic       r_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;

  logic       f_wr, f_rd, f_err_clr;
  logic [7:0] f_w_data, f_r_data;
  logic       f_r_valid, f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
  logic [3:0] f_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] sb[$];
  bit         m_ovf, m_unf, m_rv;
  logic [7:0] m_rdata;

  always #5 clk = ~clk;

  fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) dut (
    .clk(clk), .reset(reset), .wr(wr), .w_data(w_data), .rd(rd),
    .r_data(r_data), .r_valid(r_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .err_clr(err_clr), .overflow(overflow), .underflow(underflow)
  );

  fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) dut_f (
    .clk(clk), .reset(reset), .wr(f_wr), .w_data(f_w_data), .rd(f_rd),
    .r_data(f_r_data), .r_valid(f_r_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
    .err_clr(f_err_clr), .overflow(f_overflow), .underflow(f_underflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, then compare every output.
  task automatic cycle(input bit rst, input bit w, input logic [7:0] d, input bit r, input bit c);
    int  cnt;
    bit  m_full, m_empty, rd_ok, wr_ok;
    reset = rst; wr = w; w_data = d; rd = r; err_clr = c;
    @(posedge clk);
    #1;
    if (rst) begin
      sb.delete();
      m_ovf = 0; m_unf = 0; m_rv = 0; m_rdata = 8'h00;
    end else begin
      m_full  = (sb.size() == 8);
      m_empty = (sb.size() == 0);
      rd_ok   = r && !m_empty;
      wr_ok   = w && (!m_full || r);
      m_ovf   = (m_ovf && !c) || (w && m_full && !r);
      m_unf   = (m_unf && !c) || (r && m_empty);
      m_rv    = rd_ok;
      if (rd_ok) m_rdata = sb.pop_front();
      if (wr_ok) sb.push_back(d);
    end
    cnt = sb.size();
    check("count",        32'(count),        32'(cnt));
    check("empty",        32'(empty),        32'(cnt == 0));
    check("full",         32'(full),         32'(cnt == 8));
    check("almost_full",  32'(almost_full),  32'(cnt >= 6));
    check("almost_empty", 32'(almost_empty), 32'(cnt <= 2));
    check("overflow",     32'(overflow),     32'(m_ovf));
    check("underflow",    32'(underflow),    32'(m_unf));
    check("r_valid",      32'(r_valid),      32'(m_rv));
    check("r_data",       32'(r_data),       32'(m_rdata));
    reset = 0; wr = 0; rd = 0; err_clr = 0;
  endtask

  initial begin
    logic [7:0] fill1 [8];
    logic [7:0] fill4 [8];
    fill1 = '{8'd5, 8'd8, 8'd12, 8'd2, 8'd9, 8'd14, 8'd13, 8'd6};
    fill4 = '{8'd12, 8'd4, 8'd23, 8'd31, 8'd32, 8'd33, 8'd34, 8'd35};
    reset = 1; wr = 0; rd = 0; err_clr = 0; w_data = '0;
    f_wr = 0; f_rd = 0; f_err_clr = 0; f_w_data = '0;

    // Reset state
    cycle(1, 0, 8'h00, 0, 0);
    cycle(1, 1, 8'hAA, 1, 0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_rdata", 32'(r_data), 32'd0);

    // 1: fill to full, then a rejected write
    foreach (fill1[i]) cycle(0, 1, fill1[i], 0, 0);
    check("s1_full", 32'(full), 32'd1);
    cycle(0, 1, 8'd7, 0, 0);
    check("s1_count_after_ovf", 32'(count), 32'd8);
    check("s1_overflow", 32'(overflow), 32'd1);

    // 2: drain in order, then an underflowing read
    for (int i = 0; i < 8; i++) cycle(0, 0, 8'h00, 1, 0);
    check("s2_last_data", 32'(r_data), 32'd6);
    check("s2_empty", 32'(empty), 32'd1);
    cycle(0, 0, 8'h00, 1, 0);
    check("s2_underflow", 32'(underflow), 32'd1);
    check("s2_rdata_hold", 32'(r_data), 32'd6);
    check("s2_rvalid_low", 32'(r_valid), 32'd0);
    cycle(0, 0, 8'h00, 0, 1);

    // 3: simultaneous rd/wr on empty, then clear with a set-wins probe
    cycle(0, 1, 8'd17, 1, 0);
    check("s3_count", 32'(count), 32'd1);
    check("s3_underflow", 32'(underflow), 32'd1);
    cycle(0, 0, 8'h00, 1, 0);
    check("s3_data", 32'(r_data), 32'd17);
    cycle(0, 0, 8'h00, 1, 1);
    check("s3_set_wins", 32'(underflow), 32'd1);
    cycle(0, 0, 8'h00, 0, 1);
    check("s3_cleared", 32'(underflow), 32'd0);

    // 4: fill with wrap, then rd/wr while full
    foreach (fill4[i]) cycle(0, 1, fill4[i], 0, 0);
    cycle(0, 1, 8'd11, 1, 0);
    check("s4_count", 32'(count), 32'd8);
    check("s4_overflow", 32'(overflow), 32'd0);
    check("s4_data", 32'(r_data), 32'd12);
    for (int i = 0; i < 8; i++) cycle(0, 0, 8'h00, 1, 0);
    check("s4_last", 32'(r_data), 32'd11);

    // 5: reset mid-operation with wr asserted
    for (int i = 0; i < 3; i++) cycle(0, 1, 8'(40 + i), 0, 0);
    cycle(1, 1, 8'd99, 0, 0);
    check("s5_count", 32'(count), 32'd0);
    check("s5_empty", 32'(empty), 32'd1);
    cycle(0, 0, 8'h00, 1, 0);
    check("s5_underflow", 32'(underflow), 32'd1);

    // 6: FWFT instance
    f_wr = 1; f_w_data = 8'd17;
    @(posedge clk); #1;
    f_wr = 0;
    check("s6_fwft_data", 32'(f_r_data), 32'd17);
    check("s6_fwft_valid", 32'(f_r_valid), 32'd1);
    check("s6_fwft_count", 32'(f_count), 32'd1);
    @(posedge clk); #1;
    check("s6_fwft_hold", 32'(f_r_data), 32'd17);
    f_rd = 1;
    @(posedge clk); #1;
    f_rd = 0;
    check("s6_fwft_empty", 32'(f_empty), 32'd1);
    check("s6_fwft_valid_low", 32'(f_r_valid), 32'd0);
    check("s6_fwft_no_unf", 32'(f_underflow), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
